// File: rtl/scene_recovery_pkg.sv
// Shared types, Q-format constants and helpers for the scene recovery pipe.
// Mode encodings travel with each pixel through the pipeline.
package scene_recovery_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'b00,
        MODE_RECOVER = 2'b01,
        MODE_SAT     = 2'b10,
        MODE_REC_ALT = 2'b11
    } mode_e;

    localparam int T_FRAC   = 16;
    localparam int INV_FRAC = 8;

    // Clamp a signed value into [0, maxv].
    function automatic longint clamp_s(input longint v, input longint maxv);
        if (v < 0)
            return 0;
        else if (v > maxv)
            return maxv;
        else
            return v;
    endfunction

endpackage

// File: rtl/scene_recip_rom.sv
// Registered reciprocal ROM: 1/t in fixed point, built from parameters.
// Address 0 and any overflow saturate to the largest code.
module scene_recip_rom #(
    parameter int T_W      = 17,
    parameter int T_FRAC   = 16,
    parameter int INV_W    = 16,
    parameter int INV_FRAC = 8,
    parameter int ADDR_W   = 9
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [INV_W-1:0]  data_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SHIFT = T_W - ADDR_W;

    function automatic logic [INV_W-1:0] entry(input int a);
        longint num;
        longint den;
        longint q;
        num = longint'(1) << (T_FRAC + INV_FRAC);
        den = longint'(a) << SHIFT;
        if (den == 0)
            return '1;
        q = num / den;
        if (q > ((longint'(1) << INV_W) - 1))
            return '1;
        return INV_W'(q);
    endfunction

    logic [INV_W-1:0] rom [DEPTH];
    logic [INV_W-1:0] data_q;

    for (genvar a = 0; a < DEPTH; a++) begin : g_rom
        assign rom[a] = entry(a);
    end

    // ROM read register, held during stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            data_q <= '0;
        else if (en_i)
            data_q <= rom[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/scene_recovery_pipe.sv
// Five-stage scene recovery J = A + (I - A)/max(t, T_MIN) per channel,
// with saturation-gain mode, output clamping and a clipped-sample counter.
module scene_recovery_pipe #(
    parameter int DATA_W       = 8,
    parameter int NUM_CH       = 3,
    parameter int T_W          = 17,
    parameter int T_FRAC       = scene_recovery_pkg::T_FRAC,
    parameter int T_MIN        = 32768,
    parameter int INV_W        = 16,
    parameter int INV_FRAC     = scene_recovery_pkg::INV_FRAC,
    parameter int RECIP_ADDR_W = 9,
    parameter int CNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] i_pix,
    input  logic [T_W-1:0]           i_t,
    input  logic [1:0]               i_mode,
    input  logic [7:0]               i_gain,
    input  logic                     i_valid,
    output logic                     o_ready_in,
    input  logic [NUM_CH*DATA_W-1:0] i_a,
    input  logic                     i_a_valid,
    output logic [NUM_CH*DATA_W-1:0] o_pix,
    output logic                     o_valid,
    input  logic                     i_ready,
    input  logic                     i_clip_clr,
    output logic [CNT_W-1:0]         o_clip_cnt
);
    import scene_recovery_pkg::*;

    localparam int PIXW = NUM_CH * DATA_W;
    localparam int DW   = DATA_W + 1;
    localparam int PW   = DW + INV_W + 1;
    localparam int JW   = PW + 1;
    localparam longint MAXV = (longint'(1) << DATA_W) - 1;
    localparam logic signed [PW-1:0] RND = PW'(1) << (INV_FRAC - 1);
    localparam logic [T_W-1:0] TMIN_V = T_W'(T_MIN);

    logic             en;
    logic             accept;
    logic [PIXW-1:0]  a_reg_q;
    logic             a_loaded_q;
    logic [3:0]       vld_q;
    logic [PIXW-1:0]  pix_q  [4];
    logic [PIXW-1:0]  a_q    [4];
    logic [1:0]       mode_q [4];
    logic [7:0]       gain_q [4];
    logic [T_W-1:0]   t_cl_d;
    logic [T_W-1:0]   t_cl_q;
    logic [INV_W-1:0] inv;
    logic [PIXW-1:0]  opix_d;
    logic [NUM_CH-1:0] clip_w;
    logic [PIXW-1:0]  o_pix_q;
    logic             o_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] nclip;
    logic [CNT_W:0]   sum;

    assign en         = ~o_valid_q | i_ready;
    assign o_ready_in = en & a_loaded_q;
    assign accept     = i_valid & o_ready_in;
    assign t_cl_d     = (i_t < TMIN_V) ? TMIN_V : i_t;

    // Atmospheric light register; loads independently of stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg_q    <= '0;
            a_loaded_q <= 1'b0;
        end else if (i_a_valid) begin
            a_reg_q    <= i_a;
            a_loaded_q <= 1'b1;
        end
    end

    // Side-band shift register: valid, pixel, A, mode and gain per stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            t_cl_q <= '0;
            for (int k = 0; k < 4; k++) begin
                pix_q[k]  <= '0;
                a_q[k]    <= '0;
                mode_q[k] <= '0;
                gain_q[k] <= '0;
            end
        end else if (en) begin
            vld_q     <= {vld_q[2:0], accept};
            t_cl_q    <= t_cl_d;
            pix_q[0]  <= i_pix;
            a_q[0]    <= a_reg_q;
            mode_q[0] <= i_mode;
            gain_q[0] <= i_gain;
            for (int k = 1; k < 4; k++) begin
                pix_q[k]  <= pix_q[k-1];
                a_q[k]    <= a_q[k-1];
                mode_q[k] <= mode_q[k-1];
                gain_q[k] <= gain_q[k-1];
            end
        end
    end

    scene_recip_rom #(
        .T_W      (T_W),
        .T_FRAC   (T_FRAC),
        .INV_W    (INV_W),
        .INV_FRAC (INV_FRAC),
        .ADDR_W   (RECIP_ADDR_W)
    ) u_rom (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (en),
        .addr_i (t_cl_q[T_W-1 -: RECIP_ADDR_W]),
        .data_o (inv)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] i_in, a_in, a_s3, a_s4, i_s4;
        logic signed [DW-1:0] d1_q, d2_q;
        logic signed [PW-1:0] p3_q;
        logic signed [JW-1:0] j4_q;
        logic [DATA_W-1:0] out;
        logic clip;
        longint pre;

        assign i_in = i_pix[c*DATA_W +: DATA_W];
        assign a_in = a_reg_q[c*DATA_W +: DATA_W];
        assign a_s3 = a_q[2][c*DATA_W +: DATA_W];
        assign a_s4 = a_q[3][c*DATA_W +: DATA_W];
        assign i_s4 = pix_q[3][c*DATA_W +: DATA_W];

        // Per-channel arithmetic: difference, product, rounded recovery
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                d1_q <= '0;
                d2_q <= '0;
                p3_q <= '0;
                j4_q <= '0;
            end else if (en) begin
                d1_q <= $signed({1'b0, i_in}) - $signed({1'b0, a_in});
                d2_q <= d1_q;
                p3_q <= PW'(d2_q) * $signed({{(PW-INV_W){1'b0}}, inv});
                j4_q <= JW'($signed({1'b0, a_s3}))
                      + JW'((p3_q + RND) >>> INV_FRAC);
            end
        end

        // Output value by mode, with clip detection before clamping
        always_comb begin
            pre  = longint'(j4_q);
            out  = i_s4;
            clip = 1'b0;
            if (mode_q[3] == MODE_SAT)
                pre = longint'(a_s4)
                    + (((longint'(j4_q) - longint'(a_s4))
                        * longint'(gain_q[3]) + 8) >>> 4);
            if (mode_q[3] != MODE_BYPASS) begin
                out  = DATA_W'(clamp_s(pre, MAXV));
                clip = (pre < 0) || (pre > MAXV);
            end
        end

        assign opix_d[c*DATA_W +: DATA_W] = out;
        assign clip_w[c] = clip;
    end

    // Number of clipped channels in the sample entering S5
    always_comb begin
        nclip = '0;
        for (int c = 0; c < NUM_CH; c++)
            nclip = nclip + CNT_W'(clip_w[c]);
        sum = {1'b0, cnt_q} + {1'b0, nclip};
    end

    // Output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_pix_q   <= '0;
            o_valid_q <= 1'b0;
        end else if (en) begin
            o_pix_q   <= opix_d;
            o_valid_q <= vld_q[3];
        end
    end

    // Saturating clip counter; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (i_clip_clr)
            cnt_q <= '0;
        else if (en && vld_q[3])
            cnt_q <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    assign o_pix      = o_pix_q;
    assign o_valid    = o_valid_q;
    assign o_clip_cnt = cnt_q;

endmodule

// File: doc/scene_recovery_pipe.md
Name: scene_recovery_pipe

Overview:
- Parametrised, back-pressurable successor to the per-pixel scene recovery stage.
- Computes J = A + (I - A)/max(t, T_MIN) per channel for NUM_CH channels, with an optional per-pixel saturation-gain mode and output clamping.
- Counts clipped output samples.
- Sits between the transmission-estimation stage and the output/VGA writer, fed by the atmospheric-light estimator.

Parameters:
- DATA_W, 8, bits per colour channel
- NUM_CH, 3, channel count
- T_W, 17, transmission width (unsigned)
- T_FRAC, 16, fractional bits of t (65536 = 1.0)
- T_MIN, 32768, lower clamp on t
- INV_W, 16, reciprocal width
- INV_FRAC, 8, fractional bits of reciprocal
- RECIP_ADDR_W, 9, reciprocal ROM address bits
- CNT_W, 16, clip counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- i_pix  in  NUM_CH*DATA_W  hazy pixel, channel 0 in LSBs
- i_t  in  T_W  transmission for i_pix
- i_mode  in  2  00 bypass, 01 recover, 10 recover+saturation gain, 11 same as 01
- i_gain  in  8  saturation gain, unsigned Q4.4 (0x10 = 1.0)
- i_valid  in  1  pixel valid
- o_ready_in  out  1  pixel accepted when i_valid & o_ready_in
- i_a  in  NUM_CH*DATA_W  atmospheric light
- i_a_valid  in  1  load i_a
- o_pix  out  NUM_CH*DATA_W  recovered pixel
- o_valid  out  1  output valid
- i_ready  in  1  downstream ready
- i_clip_clr  in  1  synchronous clear of clip counter
- o_clip_cnt  out  CNT_W  saturating count of clamped channel samples

Behaviour:
Reset and clocking
- Reset values: all stage valids, o_valid, o_pix, o_clip_cnt, a_reg and a_loaded are 0.
- Reset mid-operation discards all in-flight pixels.

Atmospheric light
- i_a_valid loads a_reg and sets a_loaded next edge.
- A is carried with each pixel down the pipe, so an A update affects only pixels accepted after the load cycle.
- A pixel accepted in the same cycle as a load uses the old A.

Handshake
- en = ~o_valid | i_ready.
- o_ready_in = en & a_loaded.
- All stages advance only when en = 1; a stall holds every stage.
- o_pix and o_valid stay stable while o_valid & ~i_ready.
- Throughput is 1 pixel/clk. Latency is exactly 5 cycles from the accept edge to o_valid with no stall.
- i_mode and i_gain are sampled at accept and travel with the pixel.

Stages
- S1: diff_c = I_c - A_c, signed DATA_W+1 bits; t_cl = (i_t < T_MIN) ? T_MIN : i_t.
- S2: inv = ROM[t_cl >> (T_W - RECIP_ADDR_W)]. The ROM entry for address a is floor(2^(T_FRAC+INV_FRAC) / (a << (T_W - RECIP_ADDR_W))), saturated to 2^INV_W - 1; address 0 gives the maximum value.
- S3: prod_c = diff_c * inv, signed, full width.
- S4: j_c = A_c + ((prod_c + 2^(INV_FRAC-1)) >>> INV_FRAC), signed.
- S5, output register, by mode:
  - 00: o = I_c.
  - 01/11: o = clamp(j_c).
  - 10: o = clamp(A_c + (((j_c - A_c) * i_gain + 8) >>> 4)).
- clamp limits are 0 and 2^DATA_W - 1. A channel is clipped when its value before clamp is < 0 or > max.

Clip counter
- On each S5 load, o_clip_cnt increments by the number of clipped channels (0..NUM_CH), saturating at all-ones.
- Bypass mode never clips.
- i_clip_clr has priority over an increment in the same cycle; the result is 0.

Decomposition:
- Package scene_recovery_pkg holds:
  - mode encodings MODE_BYPASS, MODE_RECOVER, MODE_SAT;
  - the Q-format constants T_FRAC and INV_FRAC;
  - the clamp helper function.
- Sub-module scene_recip_rom holds the S2 reciprocal ROM, generated from the parameters and registered.
- The top module holds the handshake, the per-channel generate loop and the counter.

Test Plan:
All scenarios use the default parameters.
- Reset, then a pixel with i_valid high before any i_a_valid -> o_ready_in = 0. After loading A = (100,100,100), o_ready_in rises next cycle.
- Mode 01, I = (200,50,100), t = 65536 -> o_pix = (200,50,100) exactly 5 cycles later, clip count 0.
- Mode 01, I = (200,40,100), t = 16384 (clamped to 32768, inv = 512) -> o_pix = (255,0,100), o_clip_cnt = 2.
- Mode 10, gain 0x18, I = (120,100,80), t = 65536 -> o_pix = (130,100,70). Mode 00 with the same pixel -> (120,100,80).
- Stream 8 pixels while holding i_ready low for 3 cycles mid-stream -> no pixel lost or duplicated, output order preserved, o_pix stable during stall. Load A = (50,50,50) mid-stream -> only later-accepted pixels use the new A.
- Drive i_clip_clr in the same cycle as a clipping output -> o_clip_cnt = 0. Force 2^16 clips -> count holds at 65535. Assert rst low mid-stream -> o_valid = 0 immediately.
